// File: rtl/led_mode_ctrl.sv
// Key-driven LED pattern sequencer: debounces two active-low keys, cycles four
// display patterns on key 0, pauses/resumes stepping on key 1.
`timescale 1ns/1ps

module led_mode_ctrl #(
    parameter logic [23:0] CNT_MAX      = 24'd10_000_000,
    parameter logic [19:0] DEBOUNCE_MAX = 20'd1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       running
);

    localparam int unsigned NKEY   = 2;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned DB_W   = 20;
    localparam int unsigned LED_W  = 4;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_FLOW_L   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_FLOW_R   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK    = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PINGPONG = 2'd3;

    localparam logic [LED_W-1:0] LED_INIT = 4'b0001;
    localparam logic [LED_W-1:0] LED_ALL  = 4'b1111;
    localparam logic [LED_W-1:0] LED_NONE = 4'b0000;

    // Key synchronizers and debounce state
    logic [NKEY-1:0] sync1_q;
    logic [NKEY-1:0] sync2_q;
    logic [NKEY-1:0] stable_q;
    logic [NKEY-1:0] stable_d;
    logic [NKEY-1:0] press_c;
    logic [DB_W-1:0] db_cnt_q [NKEY];
    logic [DB_W-1:0] db_cnt_d [NKEY];

    // Step counter and pattern state
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              dir_up_q;
    logic              dir_up_d;
    logic [LED_W-1:0]  led_d;
    logic [MODE_W-1:0] mode_d;
    logic              running_d;
    logic              tick_c;
    logic [LED_W-1:0]  step_led_c;
    logic              step_up_c;

    // Debounce: accept a new level after DEBOUNCE_MAX consecutive differing samples
    always_comb begin
        stable_d = stable_q;
        press_c  = '0;
        for (int i = 0; i < NKEY; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DEBOUNCE_MAX - 20'd1) begin
                db_cnt_d[i] = '0;
                stable_d[i] = sync2_q[i];
                press_c[i]  = stable_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int i = 0; i < NKEY; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < NKEY; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign tick_c = running && (cnt_q == CNT_MAX - 24'd1);

    // Next pattern value for the current mode; any unexpected value recovers to 0001
    always_comb begin
        step_led_c = LED_INIT;
        step_up_c  = 1'b1;
        case (mode)
            MODE_FLOW_L: begin
                if ($onehot(led)) begin
                    step_led_c = {led[2:0], led[3]};
                end
            end
            MODE_FLOW_R: begin
                if ($onehot(led)) begin
                    step_led_c = {led[0], led[3:1]};
                end
            end
            MODE_BLINK: begin
                if (led == LED_ALL) begin
                    step_led_c = LED_NONE;
                end else if ((led == LED_NONE) || (led == LED_INIT)) begin
                    step_led_c = LED_ALL;
                end
            end
            MODE_PINGPONG: begin
                case (led)
                    4'b0001: begin
                        step_led_c = 4'b0010;
                        step_up_c  = 1'b1;
                    end
                    4'b0010: begin
                        step_led_c = dir_up_q ? 4'b0100 : 4'b0001;
                        step_up_c  = dir_up_q;
                    end
                    4'b0100: begin
                        step_led_c = dir_up_q ? 4'b1000 : 4'b0010;
                        step_up_c  = dir_up_q;
                    end
                    4'b1000: begin
                        step_led_c = 4'b0100;
                        step_up_c  = 1'b0;
                    end
                    default: begin
                        step_led_c = LED_INIT;
                        step_up_c  = 1'b1;
                    end
                endcase
            end
            default: begin
                step_led_c = LED_INIT;
                step_up_c  = 1'b1;
            end
        endcase
    end

    // Mode reload overrides a coincident tick; a pause still lets its tick step
    always_comb begin
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        led_d     = led;
        mode_d    = mode;
        running_d = running;

        if (running) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick_c) begin
            led_d    = step_led_c;
            dir_up_d = step_up_c;
        end
        if (press_c[0]) begin
            mode_d   = mode + MODE_W'(1);
            led_d    = LED_INIT;
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end
        if (press_c[1]) begin
            running_d = ~running;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
            led      <= LED_INIT;
            mode     <= MODE_FLOW_L;
            running  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            led      <= led_d;
            mode     <= mode_d;
            running  <= running_d;
        end
    end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Key-driven sequencer for the 4-bit board LED bank, sitting between the two raw push-buttons and the `led[3:0]` pins that the flow-LED design drives. It debounces two active-low keys, selects one of four display patterns, and steps the chosen pattern on a programmable prescaler tick. Key 0 cycles the pattern mode; key 1 pauses and resumes stepping.

## Interface
- `CNT_MAX`, 24'd10_000_000: clock cycles per pattern step (0.2 s at 50 MHz); legal range ≥ 2.
- `DEBOUNCE_MAX`, 20'd1_000_000: cycles a key level must be stable before it is accepted (20 ms at 50 MHz); legal range ≥ 2.
- `sys_clk`  in  1  system clock, 50 MHz nominal; single clock domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `key`  in  2  raw push-buttons, active-low (0 = pressed), asynchronous to `sys_clk`.
- `led`  out  4  LED drive, 1 = on, registered.
- `mode`  out  2  current pattern mode, registered.
- `running`  out  1  1 = stepping enabled, 0 = paused, registered.

## Operation
- **Reset values:**
  - `led` = 4'b0001, `mode` = 0, `running` = 1.
  - Step counter = 0, ping-pong direction = up.
  - Both debounced key levels = 1 (released); synchronizers = 1.
- **Per-key debounce:**
  - 2-FF synchronizer, then a counter that clears whenever the synced level equals the stable level and increments otherwise.
  - When the counter reaches DEBOUNCE_MAX-1, the stable level takes the synced level and the counter clears.
  - A press event is a 1-cycle pulse on the stable-level 1→0 transition. Release generates no event.
- **Step counter:**
  - Counts 0..CNT_MAX-1 while `running` = 1, then wraps to 0.
  - `tick` is asserted in the cycle where count = CNT_MAX-1.
  - While paused, the counter holds its value.
- **Modes:** on each `tick`, `led` advances as follows.
  - 0 FLOW_L: 0001→0010→0100→1000→0001.
  - 1 FLOW_R: 0001→1000→0100→0010→0001.
  - 2 BLINK: 0001 (entry) →1111→0000→1111→…
  - 3 PINGPONG: 0001→0010→0100→1000→0100→0010→0001→0010…
    - Direction flips to down when `led` = 1000 and to up when `led` = 0001; no end value repeats.
- **Key 0 press event:**
  - `mode` ← `mode`+1, wrapping 3→0.
  - `led` ← 4'b0001, step counter ← 0, direction ← up.
  - `running` is unchanged: a mode change while paused loads 0001 and stays paused.
- **Key 1 press event:** `running` ← ~`running`; `led` and the counter hold.
- **Simultaneous events:**
  - Key 0 and key 1 pulses in the same cycle: both apply (mode advance with reload, plus run toggle).
  - Key 0 pulse coinciding with `tick`: the mode reload wins; the tick is discarded.
  - Key 1 pause coinciding with `tick`: that tick's step still occurs, then stepping stops.
- **Illegal/corrupt `led` value** (not reachable in normal operation): the next `tick` loads 0001.
- **Reset mid-operation:** all registers return to reset values immediately. No pending press event survives reset.

## Timing
- All outputs are registered and change only on the `sys_clk` rising edge, or asynchronously on reset assertion.
- Reset release: the first `tick` occurs CNT_MAX cycles after the first clock edge with `sys_rst_n` = 1; `led` changes on the following edge.
- Step period is exactly CNT_MAX cycles while running.
- Key latency: from a `key` bit going low and staying low, the press pulse occurs 2 (sync) + DEBOUNCE_MAX cycles later, ±1 cycle for input alignment. `mode`, `led` and `running` update on the edge after the pulse.
- Glitches shorter than DEBOUNCE_MAX cycles produce no event.
- Pause/resume: the counter resumes from its held value, so the first step after resume arrives after the remaining count, not a full period.

## Test plan
Bench runs at T = 20 ns with CNT_MAX = 5 and DEBOUNCE_MAX = 4.

- **Reset and FLOW_L:**
  - Stimulus: reset for 21 ns, then release with keys idle.
  - Response: `led` = 0001, `mode` = 0, `running` = 1. `led` steps 0010, 0100, 1000, 0001 at 5-cycle intervals.
- **Mode cycling:**
  - Stimulus: hold key[0] low 10 cycles, release; repeat 4 times.
  - Response: `mode` goes 1, 2, 3, 0, with `led` = 0001 after each press. In mode 1 the sequence is 1000, 0100, 0010, 0001. In mode 2 it is 1111, 0000, 1111.
- **PINGPONG:**
  - Stimulus: select mode 3 and run 8 ticks.
  - Response: 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
- **Pause/resume:**
  - Stimulus: press key[1] 2 cycles after a step.
  - Response: `running` = 0, and `led` is frozen for ≥ 20 cycles. Press key[1] again: `running` = 1, and the next step comes after the remaining counter cycles (3 cycles, the 5-cycle period less the 2 elapsed).
  - Stimulus: press key[0] while paused.
  - Response: `mode` advances, `led` = 0001, `running` stays 0.
- **Bounce rejection:**
  - Stimulus: key[0] toggling every 2 cycles for 20 cycles, then released.
  - Response: no change to `mode`.
  - Stimulus: key[0] held low 3 cycles only.
  - Response: no event.
- **Simultaneous press and reset mid-run:**
  - Stimulus: key[0] and key[1] asserted on the same cycle.
  - Response: `mode`+1, `led` = 0001, `running` toggled.
  - Stimulus: assert `sys_rst_n` = 0 mid-step in mode 3.
  - Response: `led` = 0001, `mode` = 0, `running` = 1 without waiting for a clock edge.
